// File: rtl/debug_pkg.sv
// Shared debug-unit encodings: dump FSM states and word/byte sizing.
// Also used by the debug UART framer.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dumpState_t;

  localparam int DUMP_DATA_W = 32;
  localparam int BYTES_PER_WORD = DUMP_DATA_W / 8;

  function automatic int bytesPerWord(input int dataW);
    return dataW / 8;
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Streams every register-file word, MSB byte first, over a
// valid/ready byte link toward the debug UART transmitter.
module regfile_dump_reader
  import debug_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = DUMP_DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] DumpReadRegister,
  input  logic [DATA_W-1:0] DumpReadData,
  output logic [7:0]        TxData,
  output logic              TxValid,
  input  logic              TxReady,
  output logic              Busy,
  output logic              Done
);

  localparam int BPW = bytesPerWord(DATA_W);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE =
    CNT_W'(BPW - 1);

  dumpState_t state;
  dumpState_t stateNext;

  logic [ADDR_W-1:0] index;
  logic [CNT_W-1:0]  byteCnt;
  logic [DATA_W-1:0] shift;
  logic              accept;
  logic              lastByte;
  logic              lastReg;

  assign accept   = (state == ST_SEND) && TxReady;
  assign lastByte = (byteCnt == LAST_BYTE);
  assign lastReg  = (index == LAST_IDX);

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE: begin
        if (Start) stateNext = ST_LATCH;
      end
      ST_LATCH: stateNext = ST_SEND;
      ST_SEND: begin
        if (accept && lastByte)
          stateNext = lastReg ? ST_DONE : ST_LATCH;
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Word is captured once in LATCH; later writes to it are not seen.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      index   <= '0;
      byteCnt <= '0;
      shift   <= '0;
    end else begin
      if (state == ST_IDLE && Start) begin
        index <= '0;
      end
      if (state == ST_LATCH) begin
        shift   <= DumpReadData;
        byteCnt <= '0;
      end
      if (accept) begin
        shift   <= shift << 8;
        byteCnt <= byteCnt + 1'b1;
        if (lastByte && !lastReg)
          index <= index + 1'b1;
      end
    end
  end

  assign DumpReadRegister = index;
  assign TxData  = shift[DATA_W-1 -: 8];
  assign TxValid = (state == ST_SEND);
  assign Busy    = (state != ST_IDLE);
  assign Done    = (state == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a byte scoreboard.
// A second instance covers the 4 x 16-bit configuration.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        randMode;
  logic        readyFixed;
  logic        readyRand;
  logic        txReady;
  logic [4:0]  rdReg;
  logic [31:0] rdData;
  logic [7:0]  txData;
  logic        txValid;
  logic        busy;
  logic        done;
  logic [31:0] regs [32];

  logic        sStart;
  logic [1:0]  sRdReg;
  logic [15:0] sRdData;
  logic [7:0]  sTxData;
  logic        sTxValid;
  logic        sBusy;
  logic        sDone;
  logic [15:0] sRegs [4];

  int          checks = 0;
  int          errors = 0;
  int          acceptCount = 0;
  int          doneCount = 0;
  int          sDoneCount = 0;
  logic        stallPrev = 1'b0;
  logic [7:0]  prevData = 8'h00;
  logic [7:0]  expQ [$];
  logic [7:0]  sExp [$];
  logic [7:0]  sObs [$];

  always #5 clk = ~clk;

  assign rdData  = regs[rdReg];
  assign sRdData = sRegs[sRdReg];
  assign txReady = randMode ? readyRand : readyFixed;

  regfile_dump_reader dut (
    .Clock(clk), .Reset(rst), .Start(start),
    .DumpReadRegister(rdReg), .DumpReadData(rdData),
    .TxData(txData), .TxValid(txValid),
    .TxReady(txReady), .Busy(busy), .Done(done)
  );

  regfile_dump_reader #(
    .NUM_REGS(4), .ADDR_W(2), .DATA_W(16)
  ) dutSmall (
    .Clock(clk), .Reset(rst), .Start(sStart),
    .DumpReadRegister(sRdReg), .DumpReadData(sRdData),
    .TxData(sTxData), .TxValid(sTxValid),
    .TxReady(1'b1), .Busy(sBusy), .Done(sDone)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Big-instance monitor: scoreboard pop and stall stability.
  always @(negedge clk) begin
    logic [8:0] e;
    if (stallPrev) begin
      check("stall-valid", 32'(txValid), 32'd1);
      check("stall-data", 32'(txData), 32'(prevData));
    end
    if (txValid && txReady) begin
      acceptCount++;
      e = (expQ.size() > 0) ? {1'b0, expQ.pop_front()}
                            : 9'h100;
      check("tx-byte", {23'd0, 1'b0, txData}, 32'(e));
    end
    if (done) doneCount++;
    stallPrev = txValid && !txReady && !rst;
    prevData  = txData;
  end

  always @(negedge clk) begin
    if (sTxValid) sObs.push_back(sTxData);
    if (sDone) sDoneCount++;
  end

  initial begin
    readyRand = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      readyRand = ($urandom_range(0, 99) < 30);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) expQ.push_back(w[b*8 +: 8]);
  endtask

  task automatic pushDump();
    for (int i = 0; i < 32; i++) pushWord(regs[i]);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int d0;
    int n;
    d0 = doneCount;
    n = 0;
    while (doneCount == d0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "-done-seen"}, 32'(doneCount != d0), 32'd1);
  endtask

  task automatic waitAccepts(input int target);
    int n;
    n = 0;
    while (acceptCount < target && n < 2000) begin
      tick();
      n++;
    end
    check("accept-reached", 32'(acceptCount >= target), 32'd1);
  endtask

  initial begin
    int n;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    sStart = 1'b0;
    randMode = 1'b0;
    readyFixed = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    regs[8] = 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) sRegs[i] = 16'(i);
    tick(); tick(); tick();

    check("rst-valid", 32'(txValid), 32'd0);
    check("rst-busy", 32'(busy), 32'd0);
    check("rst-done", 32'(done), 32'd0);
    check("rst-reg", 32'(rdReg), 32'd0);
    check("rst-data", 32'(txData), 32'd0);
    rst = 1'b0;
    tick();

    // 1: full dump, TxReady held high, latency and length
    pushDump();
    acceptCount = 0;
    d0 = doneCount;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    check("t1-latch-busy", 32'(busy), 32'd1);
    check("t1-latch-valid", 32'(txValid), 32'd0);
    check("t1-latch-reg", 32'(rdReg), 32'd0);
    tick();
    n++;
    check("t1-send-valid", 32'(txValid), 32'd1);
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check("t1-busy-cycles", 32'(n), 32'd162);
    check("t1-done-count", 32'(doneCount - d0), 32'd1);
    check("t1-bytes", 32'(acceptCount), 32'd128);
    check("t1-queue", 32'(expQ.size()), 32'd0);

    // 2: random backpressure
    pushDump();
    acceptCount = 0;
    d0 = doneCount;
    randMode = 1'b1;
    pulseStart();
    waitDone("t2", 4000);
    randMode = 1'b0;
    tick();
    check("t2-bytes", 32'(acceptCount), 32'd128);
    check("t2-queue", 32'(expQ.size()), 32'd0);
    check("t2-done-count", 32'(doneCount - d0), 32'd1);
    check("t2-idle", 32'(busy), 32'd0);

    // 3: reset while third byte of r5 is pending
    regs[5] = 32'h1122_3344;
    pushDump();
    acceptCount = 0;
    d0 = doneCount;
    pulseStart();
    waitAccepts(22);
    check("t3-pend-valid", 32'(txValid), 32'd1);
    check("t3-pend-reg", 32'(rdReg), 32'd5);
    check("t3-pend-data", 32'(txData), 32'h33);
    rst = 1'b1;
    readyFixed = 1'b0;
    tick();
    check("t3-rst-valid", 32'(txValid), 32'd0);
    check("t3-rst-busy", 32'(busy), 32'd0);
    check("t3-rst-reg", 32'(rdReg), 32'd0);
    check("t3-no-done", 32'(doneCount - d0), 32'd0);
    rst = 1'b0;
    readyFixed = 1'b1;
    expQ.delete();
    regs[5] = 32'd5;
    pushDump();
    acceptCount = 0;
    pulseStart();
    waitDone("t3", 400);
    tick();
    check("t3-bytes", 32'(acceptCount), 32'd128);
    check("t3-queue", 32'(expQ.size()), 32'd0);

    // 4: Start during SEND ignored; Start held across DONE
    pushDump();
    acceptCount = 0;
    d0 = doneCount;
    pulseStart();
    waitAccepts(41);
    check("t4-in-r10", 32'(rdReg), 32'd10);
    pulseStart();
    waitDone("t4a", 400);
    tick(); tick();
    check("t4-idle", 32'(busy), 32'd0);
    check("t4-bytes", 32'(acceptCount), 32'd128);
    check("t4-done-count", 32'(doneCount - d0), 32'd1);
    check("t4-queue", 32'(expQ.size()), 32'd0);
    pushDump();
    pushDump();
    acceptCount = 0;
    d0 = doneCount;
    start = 1'b1;
    waitDone("t4b", 400);
    tick();
    check("t4-gap-busy", 32'(busy), 32'd0);
    tick();
    check("t4-restart-busy", 32'(busy), 32'd1);
    check("t4-restart-reg", 32'(rdReg), 32'd0);
    check("t4-restart-valid", 32'(txValid), 32'd0);
    start = 1'b0;
    waitDone("t4c", 400);
    tick();
    check("t4-bytes2", 32'(acceptCount), 32'd256);
    check("t4-done-count2", 32'(doneCount - d0), 32'd2);
    check("t4-queue2", 32'(expQ.size()), 32'd0);

    // 5: write just before r3 is latched, then during its SEND
    for (int i = 0; i < 32; i++)
      pushWord(i == 3 ? 32'hDEAD_BEEF : regs[i]);
    pulseStart();
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (busy && !txValid && rdReg == 5'd3) begin
        regs[3] = 32'hDEAD_BEEF;
        break;
      end
    end
    check("t5-latch-found", 32'(regs[3]), 32'hDEAD_BEEF);
    waitDone("t5a", 400);
    tick();
    check("t5-queue", 32'(expQ.size()), 32'd0);
    pushDump();
    pulseStart();
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (txValid && rdReg == 5'd3) begin
        regs[3] = 32'h1234_5678;
        break;
      end
    end
    check("t5-send-found", 32'(regs[3]), 32'h1234_5678);
    waitDone("t5b", 400);
    tick();
    check("t5-queue2", 32'(expQ.size()), 32'd0);

    // 6: 4 x 16-bit instance
    for (int i = 0; i < 4; i++) begin
      sExp.push_back(sRegs[i][15:8]);
      sExp.push_back(sRegs[i][7:0]);
    end
    sStart = 1'b1;
    tick();
    sStart = 1'b0;
    n = 0;
    while (sDoneCount == 0 && n < 100) begin
      tick();
      n++;
    end
    check("t6-done-seen", 32'(sDoneCount), 32'd1);
    check("t6-len-at-done", 32'(sObs.size()), 32'd8);
    check("t6-last-reg", 32'(sRdReg), 32'd3);
    tick(); tick();
    check("t6-idle", 32'(sBusy), 32'd0);
    check("t6-done-once", 32'(sDoneCount), 32'd1);
    for (int i = 0; i < 8; i++)
      check("t6-byte", 32'(sObs[i]), 32'(sExp[i]));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
